truth_table_probe: RTL and testbench
====================================

TRUTH_TABLE_PROBE -- requirements
Module: truth_table_probe

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles the probe pattern is held before sampling (legal range 2..255).
REQ-002 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a sweep; sampled on clk.
REQ-005 SHALL have port expected  input  8  reference truth-table code, latched on start acceptance.
REQ-006 SHALL have port dut_out  input  1  response of the 3-input logic block under test; asynchronous to clk.
REQ-007 SHALL have ports probe_in1, probe_in2, probe_in3  output  1 each  drive the block-under-test inputs.
REQ-008 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-010 SHALL have port table_code  output  8  measured truth-table code.
REQ-011 SHALL have port match  output  1  table_code equals latched expected; valid from done onward.

Function
REQ-012 SHALL implement states IDLE, DRIVE, SAMPLE, FINISH.
REQ-013 SHALL accept start only in IDLE; start while busy SHALL be ignored with no side effects.
REQ-014 On acceptance SHALL latch expected, clear table_code and match, set row=0, enter DRIVE next cycle.
REQ-015 SHALL drive {probe_in1,probe_in2,probe_in3} = row (probe_in1 = MSB) throughout DRIVE and SAMPLE.
REQ-016 SHALL remain in DRIVE exactly SETTLE_CYCLES cycles per row, then enter SAMPLE for exactly 1 cycle.
REQ-017 In SAMPLE SHALL write synchronized dut_out into table_code bit (7 - row); row 000 maps to bit 7, row 111 to bit 0.
REQ-018 After SAMPLE of row < 7 SHALL increment row and return to DRIVE; after row 7 SHALL enter FINISH.
REQ-019 In FINISH (1 cycle) SHALL set match = (table_code == latched expected), pulse done, then return to IDLE.
REQ-020 Start in cycle T SHALL yield done high in cycle T + 8*(SETTLE_CYCLES+1) + 2 (T+42 at default).
REQ-021 busy SHALL be high from the cycle after acceptance through the FINISH cycle inclusive, low otherwise.
REQ-022 table_code and match SHALL hold their values in IDLE until the next accepted start.
REQ-023 dut_out SHALL pass through a 2-flop synchronizer before sampling; SETTLE_CYCLES >= 2 covers its latency.
REQ-024 In IDLE, probe outputs SHALL be driven 000.
REQ-025 start asserted in the same cycle done pulses SHALL be ignored; a new start is accepted only in IDLE.

Reset
REQ-026 rst SHALL force state IDLE, row 0, settle counter 0, probe outputs 000, busy 0, done 0, table_code 0x00, match 0, synchronizer flops 0.
REQ-027 rst asserted mid-sweep SHALL abort with no done pulse; partial table_code is discarded (0x00).
REQ-028 rst SHALL take priority over start in the same cycle.

Structure
REQ-029 A shared package SHALL hold the state enum, ROW_COUNT=8, CODE_WIDTH=8 and row-to-bit mapping constant.
REQ-030 The 2-flop synchronizer SHALL be a separate sub-module named sync2 (reset synchronous, active-high).
REQ-031 Settle counter width SHALL be 8 bits; row counter 3 bits.

Verification
REQ-032 Block model realizing code 0x2D (rows 010,100,101,111 high), expected=0x2D, start at T -> done at T+42, table_code=0x2D, match=1.
REQ-033 Same model, expected=0xB4 (bit-reversed) -> table_code=0x2D, match=0; confirms bit ordering.
REQ-034 dut_out stuck at 0 then stuck at 1 -> table_code 0x00 then 0xFF, match per expected.
REQ-035 start pulsed at row 3 while busy -> ignored; single done at T+42, expected unchanged from first latch.
REQ-036 rst asserted during row 5 DRIVE -> next cycle busy=0, probes 000, table_code=0x00, no done.
REQ-037 SETTLE_CYCLES=2, 0x2D model -> done at T+26, table_code=0x2D.

Source files
------------

// File: rtl/truth_table_probe_pkg.sv
// Shared constants for the truth-table probe: state encoding, table geometry
// and the row-to-code-bit mapping.
package truth_table_probe_pkg;

  localparam int unsigned ROW_COUNT  = 8;
  localparam int unsigned CODE_WIDTH = 8;
  localparam int unsigned ROW_WIDTH  = 3;
  localparam int unsigned CNT_WIDTH  = 8;

  typedef logic [ROW_WIDTH-1:0]  row_t;
  typedef logic [CODE_WIDTH-1:0] code_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  // State encoding kept as plain constants so older tools and scripts can read it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DRIVE  = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  localparam row_t ROW_LAST = row_t'(ROW_COUNT - 1);

  // Row 000 lands in the code MSB, row 111 in the LSB.
  localparam row_t ROW_TO_BIT_BASE = row_t'(CODE_WIDTH - 1);

  function automatic row_t row_to_bit(input row_t row);
    return ROW_TO_BIT_BASE - row;
  endfunction

endpackage

// File: rtl/truth_table_probe_if.sv
// Signal bundle between the sweep controller and whoever drives and observes it.
interface truth_table_probe_if;
  import truth_table_probe_pkg::*;

  logic  start;
  code_t expected;
  logic  dut_out;
  logic  probe_in1;
  logic  probe_in2;
  logic  probe_in3;
  logic  busy;
  logic  done;
  code_t table_code;
  logic  match;

  modport master (
    output start, expected, dut_out,
    input  probe_in1, probe_in2, probe_in3, busy, done, table_code, match
  );

  modport slave (
    input  start, expected, dut_out,
    output probe_in1, probe_in2, probe_in3, busy, done, table_code, match
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;
  logic s1_d, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/truth_table_probe.sv
// Sweeps all eight input rows of a 3-input combinational block, samples its
// synchronized response per row and compares the resulting code to a reference.
module truth_table_probe
  import truth_table_probe_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  truth_table_probe_if.slave bus
);

  localparam cnt_t SETTLE_LAST = cnt_t'(SETTLE_CYCLES - 1);

  state_t state_q,    state_d;
  row_t   row_q,      row_d;
  cnt_t   settle_q,   settle_d;
  code_t  expected_q, expected_d;
  code_t  table_q,    table_d;
  logic   match_q,    match_d;
  logic   done_q,     done_d;

  logic   dut_out_sync;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (bus.dut_out),
    .q   (dut_out_sync)
  );

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    settle_d   = settle_q;
    expected_d = expected_q;
    table_d    = table_q;
    match_d    = match_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse is refused, not queued.
        if (bus.start && !done_q) begin
          expected_d = bus.expected;
          table_d    = '0;
          match_d    = 1'b0;
          row_d      = '0;
          settle_d   = '0;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + cnt_t'(1);
        end
      end
      ST_SAMPLE: begin
        table_d[row_to_bit(row_q)] = dut_out_sync;
        if (row_q == ROW_LAST) begin
          state_d = ST_FINISH;
        end else begin
          row_d   = row_q + row_t'(1);
          state_d = ST_DRIVE;
        end
      end
      ST_FINISH: begin
        match_d = (table_q == expected_q);
        done_d  = 1'b1;
        row_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      settle_q   <= '0;
      expected_q <= '0;
      table_q    <= '0;
      match_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      settle_q   <= settle_d;
      expected_q <= expected_d;
      table_q    <= table_d;
      match_q    <= match_d;
      done_q     <= done_d;
    end
  end

  logic driving;
  assign driving = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);

  assign bus.probe_in1  = driving & row_q[2];
  assign bus.probe_in2  = driving & row_q[1];
  assign bus.probe_in3  = driving & row_q[0];
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.table_code = table_q;
  assign bus.match      = match_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// Directed bench for truth_table_probe: two instances (settle 4 and settle 2)
// each driven by a behavioural 3-input block defined by an 8-bit code.
module tb_truth_table_probe;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [7:0] model_a;
  logic [7:0] model_b;
  logic [2:0] row_a;
  logic [2:0] row_b;

  truth_table_probe_if if_a ();
  truth_table_probe_if if_b ();

  truth_table_probe #(.SETTLE_CYCLES(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  truth_table_probe #(.SETTLE_CYCLES(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural block under test: row r drives code bit (7 - r).
  assign row_a = {if_a.probe_in1, if_a.probe_in2, if_a.probe_in3};
  assign row_b = {if_b.probe_in1, if_b.probe_in2, if_b.probe_in3};
  assign if_a.dut_out = model_a[3'(7 - row_a)];
  assign if_b.dut_out = model_b[3'(7 - row_b)];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? if_b.done : if_a.done;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? if_b.busy : if_a.busy;
  endfunction

  // One full sweep; returns at the negedge following the done cycle.
  task automatic sweep(input bit sel, input logic [7:0] exp_code, input int lat_req,
                       input logic [7:0] table_req, input logic match_req,
                       input bit poke_start, input string tag);
    int k;
    @(negedge clk);
    if (sel) begin if_b.start = 1'b1; if_b.expected = exp_code; end
    else     begin if_a.start = 1'b1; if_a.expected = exp_code; end
    @(negedge clk);
    if_a.start = 1'b0; if_b.start = 1'b0;
    if_a.expected = ~exp_code; if_b.expected = ~exp_code;
    check({tag, "_busy_early"}, 32'(get_busy(sel)), 32'd1);
    k = 1;
    while (!get_done(sel) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(lat_req));
    check({tag, "_table"}, 32'(sel ? if_b.table_code : if_a.table_code), 32'(table_req));
    check({tag, "_match"}, 32'(sel ? if_b.match : if_a.match), 32'(match_req));
    check({tag, "_busy_at_done"}, 32'(get_busy(sel)), 32'd0);
    if (poke_start) begin
      if (sel) if_b.start = 1'b1; else if_a.start = 1'b1;
    end
    @(negedge clk);
    if_a.start = 1'b0; if_b.start = 1'b0;
    check({tag, "_done_pulse"}, 32'(get_done(sel)), 32'd0);
    check({tag, "_busy_after"}, 32'(get_busy(sel)), 32'd0);
  endtask

  initial begin
    int k;
    int dones;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    model_a = 8'h2D;
    model_b = 8'h2D;
    if_a.start = 1'b0; if_a.expected = 8'h00;
    if_b.start = 1'b0; if_b.expected = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_busy",  32'(if_a.busy), 32'd0);
    check("rst_done",  32'(if_a.done), 32'd0);
    check("rst_table", 32'(if_a.table_code), 32'h00);
    check("rst_match", 32'(if_a.match), 32'd0);
    check("rst_probes", 32'(row_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Matching reference, then a start held during the done cycle.
    sweep(1'b0, 8'h2D, 42, 8'h2D, 1'b1, 1'b1, "match_2d");
    repeat (3) @(negedge clk);
    check("hold_table", 32'(if_a.table_code), 32'h2D);
    check("hold_match", 32'(if_a.match), 32'd1);

    // Bit-reversed reference proves the row-to-bit ordering.
    sweep(1'b0, 8'hB4, 42, 8'h2D, 1'b0, 1'b0, "reversed_b4");

    // Stuck-at responses.
    model_a = 8'h00;
    sweep(1'b0, 8'h00, 42, 8'h00, 1'b1, 1'b0, "stuck0");
    model_a = 8'hFF;
    sweep(1'b0, 8'h00, 42, 8'hFF, 1'b0, 1'b0, "stuck1");

    // Start pulsed mid-sweep at row 3 must be ignored.
    model_a = 8'h2D;
    @(negedge clk);
    if_a.start = 1'b1; if_a.expected = 8'h2D;
    @(negedge clk);
    if_a.start = 1'b0; if_a.expected = 8'h00;
    k = 1;
    dones = 0;
    while (row_a != 3'd3 && k < 200) begin @(negedge clk); k++; end
    if_a.start = 1'b1;
    @(negedge clk);
    k++;
    if_a.start = 1'b0;
    while (!if_a.done && k < 200) begin @(negedge clk); k++; end
    check("ignore_latency", 32'(k), 32'd42);
    check("ignore_match", 32'(if_a.match), 32'd1);
    repeat (60) begin
      @(negedge clk);
      if (if_a.done) dones++;
    end
    check("ignore_single_done", 32'(dones), 32'd0);

    // Reset during row 5 DRIVE aborts the sweep.
    @(negedge clk);
    if_a.start = 1'b1; if_a.expected = 8'h2D;
    @(negedge clk);
    if_a.start = 1'b0;
    k = 0;
    while (row_a != 3'd5 && k < 200) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",   32'(if_a.busy), 32'd0);
    check("abort_probes", 32'(row_a), 32'd0);
    check("abort_table",  32'(if_a.table_code), 32'h00);
    check("abort_done",   32'(if_a.done), 32'd0);
    rst = 1'b0;
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (if_a.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // Reset wins over a simultaneous start.
    if_a.start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if_a.start = 1'b0;
    check("rst_over_start", 32'(if_a.busy), 32'd0);

    // Short settle instance.
    sweep(1'b1, 8'h2D, 26, 8'h2D, 1'b1, 1'b0, "settle2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
